// File: rtl/hs_bridge_pkg.sv
// Shared definitions for the self-timed to clocked bridge:
// handshake protocol selectors, 4-phase FSM states, pointer-width helper.
package hs_bridge_pkg;

  localparam int unsigned PHASE_4 = 4;
  localparam int unsigned PHASE_2 = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ACKED = 1'b1
  } hs_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/hs_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit, reset to 0.
// Ports: clk, reset (sync, active-high), d (async input), q (synchronised output).
module hs_sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hs_async_sync_fifo.sv
// Bridge from a bundled-data req/ack channel (4-phase or 2-phase) into a
// show-ahead valid/ready FIFO in the clk domain.
// Ports: clk, reset (sync, active-high); in_req/in_data/in_ack upstream
// handshake; out_valid/out_ready/out_data downstream; level = occupancy.
module hs_async_sync_fifo
  import hs_bridge_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PHASE       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_req,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [clog2(DEPTH):0]  level
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic             req_s;
  logic             push;
  logic             pop;
  logic             full;
  logic             ack_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] level_d;
  logic [WIDTH-1:0] mem [DEPTH];

  // Only this synchroniser ever samples the asynchronous request.
  hs_sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_req),
    .q     (req_s)
  );

  // Full uses the current level only: a same-cycle pop never frees a slot for a push.
  assign full   = (level == PTR_W'(DEPTH));
  assign pop    = out_valid & out_ready;
  assign in_ack = ack_q;

  generate
    if (PHASE == PHASE_4) begin : g_phase4
      hs_state_e state_q;
      hs_state_e state_d;
      logic      ack_d;

      // Handshake state register.
      always_ff @(posedge clk) begin
        if (reset) begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          ack_q   <= ack_d;
        end
      end

      // Return-to-zero: accept on req high, release ack on req low.
      always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        push    = 1'b0;
        case (state_q)
          IDLE: begin
            if (req_s && !full) begin
              push    = 1'b1;
              ack_d   = 1'b1;
              state_d = ACKED;
            end
          end
          ACKED: begin
            if (!req_s) begin
              ack_d   = 1'b0;
              state_d = IDLE;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end else begin : g_phase2
      // Transition signalling: a transfer is pending while req and ack differ.
      assign push = (req_s ^ ack_q) & ~full;

      always_ff @(posedge clk) begin
        if (reset) ack_q <= 1'b0;
        else       ack_q <= ack_q ^ push;
      end
    end
  endgenerate

  // Occupancy after this cycle's push/pop.
  always_comb begin
    level_d = level;
    if (push && !pop)      level_d = level + PTR_W'(1);
    else if (!push && pop) level_d = level - PTR_W'(1);
  end

  // Pointers, level and valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + PTR_W'(push);
      rd_ptr    <= rd_ptr + PTR_W'(pop);
      level     <= level_d;
      out_valid <= (level_d != '0);
    end
  end

  // Storage, not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= in_data;
  end

  assign out_data = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: tb/tb_hs_async_sync_fifo.sv
// Bench for hs_async_sync_fifo: one 4-phase and one 2-phase instance,
// compared against a handshake-count occupancy model and expected word queues.
module tb_hs_async_sync_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       in_req4 = 1'b0;
  logic [7:0] in_data4 = '0;
  logic       in_ack4;
  logic       out_valid4;
  logic       out_ready4 = 1'b0;
  logic [7:0] out_data4;
  logic [2:0] level4;

  logic       in_req2 = 1'b0;
  logic [7:0] in_data2 = '0;
  logic       in_ack2;
  logic       out_valid2;
  logic       out_ready2 = 1'b0;
  logic [7:0] out_data2;
  logic [2:0] level2;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx4[$];
  logic [7:0] exp4[$];
  logic [7:0] rx2[$];
  logic [7:0] exp2[$];
  int mlvl4 = 0, mlvl2 = 0;
  int lvl_err4 = 0, lvl_err2 = 0;
  int max_lvl4 = 0, max_lvl2 = 0;
  bit rnd4 = 1'b0, rnd2 = 1'b0;

  always #5 clk = ~clk;

  hs_async_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2), .PHASE(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .in_req    (in_req4),
    .in_data   (in_data4),
    .in_ack    (in_ack4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_data  (out_data4),
    .level     (level4)
  );

  hs_async_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2), .PHASE(2)) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .in_req    (in_req2),
    .in_data   (in_data2),
    .in_ack    (in_ack2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_data  (out_data2),
    .level     (level2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on the 4-phase side: log the word popped at the coming edge,
  // then update the model level from observed ack rises and pops.
  task automatic step4();
    logic pop;
    logic ack_prev;
    if (rnd4) out_ready4 = 1'($urandom_range(0, 1));
    pop = out_valid4 && out_ready4;
    if (pop) rx4.push_back(out_data4);
    ack_prev = in_ack4;
    tick();
    if (in_ack4 && !ack_prev) mlvl4++;
    if (pop) mlvl4--;
    if (level4 !== 3'(mlvl4) || out_valid4 !== (mlvl4 != 0)) lvl_err4++;
    if (int'(level4) > max_lvl4) max_lvl4 = int'(level4);
  endtask

  // One cycle on the 2-phase side: every ack toggle is one accepted word.
  task automatic step2();
    logic pop;
    logic ack_prev;
    if (rnd2) out_ready2 = 1'($urandom_range(0, 1));
    pop = out_valid2 && out_ready2;
    if (pop) rx2.push_back(out_data2);
    ack_prev = in_ack2;
    tick();
    if (in_ack2 !== ack_prev) mlvl2++;
    if (pop) mlvl2--;
    if (level2 !== 3'(mlvl2) || out_valid2 !== (mlvl2 != 0)) lvl_err2++;
    if (int'(level2) > max_lvl2) max_lvl2 = int'(level2);
  endtask

  // Full 4-phase handshake as the upstream stage would perform it.
  task automatic hs4_send(input logic [7:0] d, output bit ok);
    int n;
    ok = 1'b1;
    in_data4 = d;
    in_req4 = 1'b1;
    n = 0;
    while (in_ack4 !== 1'b1 && n < 40) begin step4(); n++; end
    if (in_ack4 !== 1'b1) ok = 1'b0;
    in_req4 = 1'b0;
    n = 0;
    while (in_ack4 !== 1'b0 && n < 40) begin step4(); n++; end
    if (in_ack4 !== 1'b0) ok = 1'b0;
  endtask

  task automatic clr4();
    rx4.delete(); exp4.delete(); lvl_err4 = 0; max_lvl4 = 0;
  endtask

  task automatic clr2();
    rx2.delete(); exp2.delete(); lvl_err2 = 0; max_lvl2 = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (in_ack4 !== 1'b0) begin errors++; $display("FAIL reset_ack4: got %b want 0", in_ack4); end
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid4: got %b want 0", out_valid4); end
    checks++; if (level4 !== 3'd0) begin errors++; $display("FAIL reset_level4: got %0d want 0", level4); end
    checks++; if (in_ack2 !== 1'b0) begin errors++; $display("FAIL reset_ack2: got %b want 0", in_ack2); end
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid2: got %b want 0", out_valid2); end
    checks++; if (level2 !== 3'd0) begin errors++; $display("FAIL reset_level2: got %0d want 0", level2); end
    reset = 1'b0;
    mlvl4 = 0;
    mlvl2 = 0;
  endtask

  task automatic test_single_4ph();
    int n;
    clr4();
    out_ready4 = 1'b1;
    in_data4 = 8'hA5;
    in_req4 = 1'b1;
    n = 0;
    while (in_ack4 !== 1'b1 && n < 20) begin step4(); n++; end
    checks++; if (n != 3) begin errors++; $display("FAIL single_ack_rise_latency: got %0d want 3", n); end
    checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid4); end
    checks++; if (out_data4 !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", out_data4); end
    checks++; if (level4 !== 3'd1) begin errors++; $display("FAIL single_level: got %0d want 1", level4); end
    step4();
    checks++; if (level4 !== 3'd0 || out_valid4 !== 1'b0) begin errors++; $display("FAIL single_drain: got level %0d valid %b want 0 0", level4, out_valid4); end
    in_req4 = 1'b0;
    n = 0;
    while (in_ack4 !== 1'b0 && n < 20) begin step4(); n++; end
    checks++; if (n != 3) begin errors++; $display("FAIL single_ack_fall_latency: got %0d want 3", n); end
    checks++; if (rx4.size() != 1 || rx4[0] !== 8'hA5) begin errors++; $display("FAIL single_rx: got %0d words want 1 word a5", rx4.size()); end
    checks++; if (lvl_err4 != 0) begin errors++; $display("FAIL single_level_model: got %0d mismatching cycles want 0", lvl_err4); end
  endtask

  task automatic test_stall_4ph();
    bit ok;
    int n_ok;
    int n;
    clr4();
    out_ready4 = 1'b0;
    n_ok = 0;
    for (int i = 1; i <= 4; i++) begin
      exp4.push_back(8'(i));
      hs4_send(8'(i), ok);
      if (ok) n_ok++;
    end
    checks++; if (n_ok != 4) begin errors++; $display("FAIL stall_fill_handshakes: got %0d want 4", n_ok); end
    checks++; if (level4 !== 3'd4) begin errors++; $display("FAIL stall_level_full: got %0d want 4", level4); end
    exp4.push_back(8'h05);
    in_data4 = 8'h05;
    in_req4 = 1'b1;
    repeat (10) step4();
    checks++; if (in_ack4 !== 1'b0 || level4 !== 3'd4) begin errors++; $display("FAIL stall_fifth_held: got ack %b level %0d want 0 4", in_ack4, level4); end
    out_ready4 = 1'b1;
    n = 0;
    while (in_ack4 !== 1'b1 && n < 40) begin step4(); n++; end
    checks++; if (in_ack4 !== 1'b1) begin errors++; $display("FAIL stall_fifth_ack: got %b want 1", in_ack4); end
    in_req4 = 1'b0;
    n = 0;
    while (in_ack4 !== 1'b0 && n < 40) begin step4(); n++; end
    repeat (10) step4();
    checks++; if (rx4.size() != exp4.size()) begin errors++; $display("FAIL stall_rx_count: got %0d want %0d", rx4.size(), exp4.size()); end
    for (int i = 0; i < exp4.size() && i < rx4.size(); i++) begin
      checks++; if (rx4[i] !== exp4[i]) begin errors++; $display("FAIL stall_rx[%0d]: got %h want %h", i, rx4[i], exp4[i]); end
    end
    checks++; if (lvl_err4 != 0 || level4 !== 3'd0) begin errors++; $display("FAIL stall_level_model: got %0d bad cycles level %0d want 0 0", lvl_err4, level4); end
  endtask

  task automatic test_full_pop();
    bit ok;
    int n;
    clr4();
    out_ready4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp4.push_back(8'h21 + 8'(i));
      hs4_send(8'h21 + 8'(i), ok);
    end
    exp4.push_back(8'h25);
    in_data4 = 8'h25;
    in_req4 = 1'b1;
    repeat (6) step4();
    checks++; if (level4 !== 3'd4 || in_ack4 !== 1'b0) begin errors++; $display("FAIL fullpop_pre: got level %0d ack %b want 4 0", level4, in_ack4); end
    out_ready4 = 1'b1;
    checks++; if (out_data4 !== 8'h21) begin errors++; $display("FAIL fullpop_head: got %h want 21", out_data4); end
    step4();
    out_ready4 = 1'b0;
    checks++; if (level4 !== 3'd3 || in_ack4 !== 1'b0) begin errors++; $display("FAIL fullpop_pop_edge: got level %0d ack %b want 3 0", level4, in_ack4); end
    step4();
    checks++; if (level4 !== 3'd4 || in_ack4 !== 1'b1) begin errors++; $display("FAIL fullpop_push_edge: got level %0d ack %b want 4 1", level4, in_ack4); end
    in_req4 = 1'b0;
    n = 0;
    while (in_ack4 !== 1'b0 && n < 40) begin step4(); n++; end
    out_ready4 = 1'b1;
    repeat (12) step4();
    checks++; if (rx4.size() != exp4.size()) begin errors++; $display("FAIL fullpop_rx_count: got %0d want %0d", rx4.size(), exp4.size()); end
    for (int i = 0; i < exp4.size() && i < rx4.size(); i++) begin
      checks++; if (rx4[i] !== exp4[i]) begin errors++; $display("FAIL fullpop_rx[%0d]: got %h want %h", i, rx4[i], exp4[i]); end
    end
    checks++; if (lvl_err4 != 0) begin errors++; $display("FAIL fullpop_level_model: got %0d bad cycles want 0", lvl_err4); end
  endtask

  task automatic test_wrap_4ph();
    bit ok;
    int n_ok;
    clr4();
    rnd4 = 1'b1;
    n_ok = 0;
    for (int i = 0; i < 20; i++) begin
      exp4.push_back(8'(i));
      hs4_send(8'(i), ok);
      if (ok) n_ok++;
    end
    rnd4 = 1'b0;
    out_ready4 = 1'b1;
    repeat (12) step4();
    checks++; if (n_ok != 20) begin errors++; $display("FAIL wrap_handshakes: got %0d want 20", n_ok); end
    checks++; if (rx4.size() != exp4.size()) begin errors++; $display("FAIL wrap_rx_count: got %0d want %0d", rx4.size(), exp4.size()); end
    for (int i = 0; i < exp4.size() && i < rx4.size(); i++) begin
      checks++; if (rx4[i] !== exp4[i]) begin errors++; $display("FAIL wrap_rx[%0d]: got %h want %h", i, rx4[i], exp4[i]); end
    end
    checks++; if (max_lvl4 > 4) begin errors++; $display("FAIL wrap_max_level: got %0d want <=4", max_lvl4); end
    checks++; if (lvl_err4 != 0) begin errors++; $display("FAIL wrap_level_model: got %0d bad cycles want 0", lvl_err4); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    clr4();
    out_ready4 = 1'b0;
    hs4_send(8'h31, ok);
    in_data4 = 8'h32;
    in_req4 = 1'b1;
    n = 0;
    while (in_ack4 !== 1'b1 && n < 20) begin step4(); n++; end
    checks++; if (level4 !== 3'd2 || in_ack4 !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got level %0d ack %b want 2 1", level4, in_ack4); end
    in_data4 = 8'h34;
    reset = 1'b1;
    tick();
    checks++; if (in_ack4 !== 1'b0 || level4 !== 3'd0 || out_valid4 !== 1'b0) begin
      errors++; $display("FAIL rstmid_cleared: got ack %b level %0d valid %b want 0 0 0", in_ack4, level4, out_valid4);
    end
    reset = 1'b0;
    mlvl4 = 0;
    mlvl2 = 0;
    clr4();
    exp4.push_back(8'h34);
    n = 0;
    while (in_ack4 !== 1'b1 && n < 20) begin step4(); n++; end
    checks++; if (n != 3) begin errors++; $display("FAIL rstmid_new_latency: got %0d want 3", n); end
    checks++; if (out_data4 !== 8'h34 || level4 !== 3'd1) begin errors++; $display("FAIL rstmid_new_word: got %h level %0d want 34 1", out_data4, level4); end
    in_req4 = 1'b0;
    n = 0;
    while (in_ack4 !== 1'b0 && n < 20) begin step4(); n++; end
    out_ready4 = 1'b1;
    repeat (6) step4();
    checks++; if (rx4.size() != 1 || rx4[0] !== 8'h34) begin errors++; $display("FAIL rstmid_rx: got %0d words want 1 word 34", rx4.size()); end
    checks++; if (lvl_err4 != 0) begin errors++; $display("FAIL rstmid_level_model: got %0d bad cycles want 0", lvl_err4); end
  endtask

  task automatic test_phase2();
    int n;
    int acks;
    int first_lat;
    clr2();
    out_ready2 = 1'b1;
    acks = 0;
    first_lat = -1;
    for (int i = 0; i < 8; i++) begin
      in_data2 = 8'h10 + 8'(i);
      exp2.push_back(in_data2);
      in_req2 = ~in_req2;
      n = 0;
      while (in_ack2 !== in_req2 && n < 20) begin step2(); n++; end
      if (in_ack2 === in_req2) acks++;
      if (i == 0) first_lat = n;
    end
    repeat (6) step2();
    checks++; if (first_lat != 3) begin errors++; $display("FAIL ph2_latency: got %0d want 3", first_lat); end
    checks++; if (acks != 8) begin errors++; $display("FAIL ph2_ack_toggles: got %0d want 8", acks); end
    checks++; if (rx2.size() != exp2.size()) begin errors++; $display("FAIL ph2_rx_count: got %0d want %0d", rx2.size(), exp2.size()); end
    for (int i = 0; i < exp2.size() && i < rx2.size(); i++) begin
      checks++; if (rx2[i] !== exp2[i]) begin errors++; $display("FAIL ph2_rx[%0d]: got %h want %h", i, rx2[i], exp2[i]); end
    end
    checks++; if (lvl_err2 != 0) begin errors++; $display("FAIL ph2_level_model: got %0d bad cycles want 0", lvl_err2); end
  endtask

  task automatic test_random_2ph();
    int n;
    int acks;
    clr2();
    rnd2 = 1'b1;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      in_data2 = 8'($urandom_range(0, 255));
      exp2.push_back(in_data2);
      in_req2 = ~in_req2;
      n = 0;
      while (in_ack2 !== in_req2 && n < 40) begin step2(); n++; end
      if (in_ack2 === in_req2) acks++;
    end
    rnd2 = 1'b0;
    out_ready2 = 1'b1;
    repeat (12) step2();
    checks++; if (acks != 30) begin errors++; $display("FAIL rnd2_ack_toggles: got %0d want 30", acks); end
    checks++; if (rx2.size() != exp2.size()) begin errors++; $display("FAIL rnd2_rx_count: got %0d want %0d", rx2.size(), exp2.size()); end
    for (int i = 0; i < exp2.size() && i < rx2.size(); i++) begin
      checks++; if (rx2[i] !== exp2[i]) begin errors++; $display("FAIL rnd2_rx[%0d]: got %h want %h", i, rx2[i], exp2[i]); end
    end
    checks++; if (max_lvl2 > 4) begin errors++; $display("FAIL rnd2_max_level: got %0d want <=4", max_lvl2); end
    checks++; if (lvl_err2 != 0 || level2 !== 3'd0) begin errors++; $display("FAIL rnd2_level_model: got %0d bad cycles level %0d want 0 0", lvl_err2, level2); end
  endtask

  initial begin
    test_reset();
    test_single_4ph();
    test_stall_4ph();
    test_full_pop();
    test_wrap_4ph();
    test_reset_mid();
    test_phase2();
    test_random_2ph();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
